// File: rtl/myniosiicpu_gpio_pkg.sv
// Shared constants for the GPIO PIO: register word addresses and edge-detect modes.
package myniosiicpu_gpio_pkg;

  localparam logic [2:0] GPIO_ADDR_DATA    = 3'd0;
  localparam logic [2:0] GPIO_ADDR_DIR     = 3'd1;
  localparam logic [2:0] GPIO_ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] GPIO_ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] GPIO_ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] GPIO_ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/myniosiicpu_gpio_sync.sv
// Pin input path: two-flop synchroniser, history flop and per-bit edge detector.
module myniosiicpu_gpio_sync
  import myniosiicpu_gpio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             prime_en,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [WIDTH-1:0] hist;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      hist   <= '0;
    end else begin
      sync_1 <= in_port;
      sync_2 <= sync_1;
      hist   <= sync_2;
    end
  end

  assign rise     = sync_2 & ~hist;
  assign fall     = ~sync_2 & hist;
  assign sync_val = sync_2;

  // Held off until prime_en so reset-time zeros in the pipeline never look like edges.
  always_comb begin
    edge_det = '0;
    if (prime_en) begin
      if (EDGE_MODE == EDGE_FALL)     edge_det = fall;
      else if (EDGE_MODE == EDGE_ANY) edge_det = rise | fall;
      else                            edge_det = rise;
    end
  end

endmodule

// File: rtl/myniosiicpu_gpio_pio.sv
// Avalon-MM GPIO slave: output/direction registers, edge capture with maskable irq, registered reads.
module myniosiicpu_gpio_pio
  import myniosiicpu_gpio_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] OUT_RESET = '0,
  parameter logic [WIDTH-1:0] DIR_RESET = '0,
  parameter int               EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe
);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wd;
  logic             unused_writedata;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_det;
  logic [1:0]       prime_cnt;
  logic             prime_en;
  logic [31:0]      rd_word;

  assign wr_en            = chipselect & ~write_n;
  assign rd_en            = chipselect & write_n;
  assign wd               = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  // Counts the three cycles needed to fill sync_1, sync_2 and hist with real pin values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               prime_cnt <= 2'd0;
    else if (prime_cnt != 2'd3) prime_cnt <= prime_cnt + 2'd1;
  end

  assign prime_en = (prime_cnt == 2'd3);

  myniosiicpu_gpio_sync #(
    .WIDTH     (WIDTH),
    .EDGE_MODE (EDGE_MODE)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .prime_en (prime_en),
    .in_port  (in_port),
    .sync_val (sync_val),
    .edge_det (edge_det)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= OUT_RESET;
      dir_reg  <= DIR_RESET;
      mask_reg <= '0;
    end else if (wr_en) begin
      case (address)
        GPIO_ADDR_DATA:    out_reg  <= wd;
        GPIO_ADDR_DIR:     dir_reg  <= wd;
        GPIO_ADDR_IRQMASK: mask_reg <= wd;
        GPIO_ADDR_OUTSET:  out_reg  <= out_reg | wd;
        GPIO_ADDR_OUTCLR:  out_reg  <= out_reg & ~wd;
        default: ;
      endcase
    end
  end

  assign cap_clr = (wr_en && address == GPIO_ADDR_EDGECAP) ? wd : '0;

  // Set is ORed in after the clear so a new edge survives a simultaneous write-1 clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cap_reg <= '0;
    else          cap_reg <= (cap_reg & ~cap_clr) | edge_det;
  end

  always_comb begin
    rd_word = '0;
    case (address)
      GPIO_ADDR_DATA:    rd_word[WIDTH-1:0] = (out_reg & dir_reg) | (sync_val & ~dir_reg);
      GPIO_ADDR_DIR:     rd_word[WIDTH-1:0] = dir_reg;
      GPIO_ADDR_IRQMASK: rd_word[WIDTH-1:0] = mask_reg;
      GPIO_ADDR_EDGECAP: rd_word[WIDTH-1:0] = cap_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_word;
  end

  assign irq      = |(cap_reg & mask_reg);
  assign out_port = out_reg;
  assign oe       = dir_reg;

endmodule

// File: tb/tb_myniosiicpu_gpio_pio.sv
// Bench for the GPIO PIO: directed scenarios plus randomized bus/pin traffic against a pin-history model.
module tb_myniosiicpu_gpio_pio;

  localparam int EM = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  in_port = 8'h00;
  logic [7:0]  out_port;
  logic [7:0]  oe;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_out, m_dir, m_mask, m_cap, m_rd;
  int         edge_cnt;
  logic [7:0] pin_q[$];

  myniosiicpu_gpio_pio #(
    .WIDTH     (8),
    .OUT_RESET (8'hA5),
    .DIR_RESET (8'hFF),
    .EDGE_MODE (EM)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pin_ago(int k);
    return (k < pin_q.size()) ? pin_q[k] : 8'h00;
  endfunction

  task automatic model_reset();
    m_out = 8'hA5; m_dir = 8'hFF; m_mask = 8'h00; m_cap = 8'h00; m_rd = 8'h00;
    edge_cnt = 0;
    pin_q.delete();
  endtask

  // One clock edge: the model sees the pin as it was two edges ago and detects
  // edges between the samples two and three edges ago, only from the 4th edge after reset.
  task automatic tick();
    logic [7:0] seen, prev, edges, clr;
    @(posedge clk);
    edge_cnt++;
    seen = pin_ago(1);
    prev = pin_ago(2);
    edges = 8'h00;
    if (edge_cnt >= 4) begin
      if (EM == 1)      edges = ~seen & prev;
      else if (EM == 2) edges = seen ^ prev;
      else              edges = seen & ~prev;
    end
    if (chipselect && write_n) begin
      case (address)
        3'd0:    m_rd = (m_out & m_dir) | (seen & ~m_dir);
        3'd1:    m_rd = m_dir;
        3'd2:    m_rd = m_mask;
        3'd3:    m_rd = m_cap;
        default: m_rd = 8'h00;
      endcase
    end
    clr = (chipselect && !write_n && address == 3'd3) ? writedata[7:0] : 8'h00;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_out = writedata[7:0];
        3'd1: m_dir = writedata[7:0];
        3'd2: m_mask = writedata[7:0];
        3'd4: m_out = m_out | writedata[7:0];
        3'd5: m_out = m_out & ~writedata[7:0];
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr) | edges;
    pin_q.push_front(in_port);
    if (pin_q.size() > 4) void'(pin_q.pop_back());
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a; writedata = $urandom();
    tick();
    chipselect = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] pins);
    in_port = pins; chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL reset_out: got %h want a5", out_port); end
    n_checks++;
    if (oe !== 8'hFF) begin n_fail++; $display("FAIL reset_oe: got %h want ff", oe); end
    n_checks++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin n_fail++; $display("FAIL reset_irq_rd: got irq=%b rd=%h want 0/0", irq, readdata); end
    rd(3'd0);
    n_checks++;
    if (readdata !== 32'h000000A5) begin n_fail++; $display("FAIL reset_read_data: got %h want 000000a5", readdata); end
  endtask

  task automatic test_set_clr();
    wr(3'd0, 32'hFFFF_FF0F);
    n_checks++;
    if (out_port !== 8'h0F) begin n_fail++; $display("FAIL data_write: got %h want 0f", out_port); end
    wr(3'd4, 32'h0000_00F0);
    n_checks++;
    if (out_port !== 8'hFF) begin n_fail++; $display("FAIL outset: got %h want ff", out_port); end
    wr(3'd5, 32'h0000_0081);
    n_checks++;
    if (out_port !== 8'h7E) begin n_fail++; $display("FAIL outclr: got %h want 7e", out_port); end
    wr(3'd6, 32'h0000_0000);
    wr(3'd7, 32'h0000_0000);
    n_checks++;
    if (out_port !== 8'h7E || oe !== 8'hFF) begin n_fail++; $display("FAIL reserved_write: got out=%h oe=%h want 7e/ff", out_port, oe); end
    for (int a = 4; a < 8; a++) begin
      rd(3'd1);
      rd(3'(a));
      n_checks++;
      if (readdata !== 32'h0) begin n_fail++; $display("FAIL read_zero_addr%0d: got %h want 0", a, readdata); end
    end
  endtask

  task automatic test_dir_mix();
    in_port = 8'h00;
    wr(3'd1, 32'h0F);
    wr(3'd0, 32'h05);
    in_port = 8'hA0;
    tick();
    rd(3'd0);
    n_checks++;
    if (readdata !== {24'h0, m_rd} || readdata === 32'hA5) begin n_fail++; $display("FAIL dir_mix_early: got %h want %h", readdata, {24'h0, m_rd}); end
    rd(3'd0);
    n_checks++;
    if (readdata !== 32'h000000A5) begin n_fail++; $display("FAIL dir_mix: got %h want 000000a5", readdata); end
  endtask

  task automatic test_edge_capture();
    do_reset(8'h00);
    repeat (4) tick();
    wr(3'd2, 32'h01);
    in_port = 8'h01;
    tick(); tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_early: got irq=%b want 0", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq: got irq=%b want 1", irq); end
    rd(3'd3);
    n_checks++;
    if (readdata !== 32'h01) begin n_fail++; $display("FAIL rise_cap: got %h want 00000001", readdata); end
    wr(3'd3, 32'h01);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL cap_clear_irq: got irq=%b want 0", irq); end
    in_port = 8'h00;
    repeat (4) tick();
    rd(3'd3);
    n_checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL fall_nocap: got %h irq=%b want 0/0", readdata, irq); end
  endtask

  task automatic test_set_wins();
    wr(3'd2, 32'h04);
    in_port = 8'h04;
    tick(); tick();
    wr(3'd3, 32'h04);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got irq=%b want 1", irq); end
    rd(3'd3);
    n_checks++;
    if (readdata !== 32'h04) begin n_fail++; $display("FAIL set_wins_cap: got %h want 00000004", readdata); end
  endtask

  task automatic test_prime();
    do_reset(8'hFF);
    wr(3'd2, 32'hFF);
    repeat (6) tick();
    rd(3'd3);
    n_checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL prime: got cap=%h irq=%b want 0/0", readdata, irq); end
    in_port = 8'h7F;
    repeat (3) tick();
    in_port = 8'hFF;
    repeat (3) tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL post_prime_rise: got irq=%b want 1", irq); end
  endtask

  task automatic test_reset_midwrite();
    wr(3'd1, 32'h00);
    wr(3'd0, 32'h11);
    wr(3'd2, 32'hFF);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h3C;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (oe !== 8'hFF || out_port !== 8'hA5) begin n_fail++; $display("FAIL async_reset: got oe=%h out=%h want ff/a5", oe, out_port); end
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    n_checks++;
    if (out_port !== 8'hA5 || irq !== 1'b0 || readdata !== 32'h0) begin n_fail++; $display("FAIL midwrite_lost: got out=%h irq=%b rd=%h want a5/0/0", out_port, irq, readdata); end
    reset_n = 1'b1;
    rd(3'd2);
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL mask_reset: got %h want 0", readdata); end
  endtask

  task automatic test_random();
    do_reset(8'($urandom()));
    for (int i = 0; i < 400; i++) begin
      chipselect = 1'($urandom_range(0, 1));
      write_n = 1'($urandom_range(0, 1));
      address = 3'($urandom_range(0, 7));
      writedata = $urandom();
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom());
      tick();
      n_checks++;
      if (out_port !== m_out || oe !== m_dir) begin n_fail++; $display("FAIL rand_out[%0d]: got out=%h oe=%h want %h/%h", i, out_port, oe, m_out, m_dir); end
      n_checks++;
      if (readdata !== {24'h0, m_rd}) begin n_fail++; $display("FAIL rand_rd[%0d]: got %h want %h", i, readdata, {24'h0, m_rd}); end
      n_checks++;
      if (irq !== |(m_cap & m_mask)) begin n_fail++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, |(m_cap & m_mask)); end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set_clr();
    test_dir_mix();
    test_edge_capture();
    test_set_wins();
    test_prime();
    test_reset_midwrite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/myniosiicpu_gpio_pio.md
# myniosiicpu_gpio_pio

Parametrised Avalon-MM general-purpose I/O peripheral for the Nios II system, successor to the fixed 8-bit output-only LED PIO. Per-bit direction control, atomic set/clear of output bits, a synchronised input path with edge capture, and a maskable level interrupt to the CPU. Sits on the system interconnect as a 32-bit slave with one-cycle read latency; `out_port`/`oe` drive board tri-state buffers, and `in_port` comes from pins.

## Interface
- `WIDTH`, 8: number of GPIO bits, 1..32.
- `OUT_RESET`, 0: reset value of the output data register, `WIDTH` bits.
- `DIR_RESET`, 0: reset value of the direction register (1 = output), `WIDTH` bits.
- `EDGE_MODE`, 0: 0 = rising, 1 = falling, 2 = any edge.

- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 3: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, valid with `chipselect`.
- `writedata` in 32: write data; bits above `WIDTH` ignored.
- `readdata` out 32: registered read data; bits above `WIDTH` read 0.
- `irq` out 1: level interrupt, active high.
- `in_port` in `WIDTH`: asynchronous pin inputs.
- `out_port` out `WIDTH`: output data register.
- `oe` out `WIDTH`: direction register (output enable per bit).

## Operation
- Register map (word address):
  - 0 DATA: write loads the output register. Read returns the output register bit where `oe`=1, and the synchronised input where `oe`=0.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns captured edges. Writing 1 clears a bit; writing 0 leaves it unchanged.
  - 4 OUTSET: write ORs into the output register; reads as 0.
  - 5 OUTCLR: write clears bits of the output register where the write data is 1; reads as 0.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- A write occurs when `chipselect`=1 and `write_n`=0. A read occurs when `chipselect`=1 and `write_n`=1.
- Input path:
  - Two-flop synchroniser on `in_port`, then one history flop.
  - An edge is detected per `EDGE_MODE`, comparing synchroniser output against the history flop.
- Edge capture:
  - Each detected edge sets its EDGECAP bit regardless of mask and regardless of `oe`.
  - If a set and a write-1 clear hit the same bit in the same cycle, the set wins.
- Post-reset priming:
  - A 2-bit counter suppresses edge detection for the first 3 cycles after reset deassertion, until the synchroniser and history flops hold real pin values.
  - As a result, a pin already high at reset does not produce a rising capture.
- `irq` = OR of (EDGECAP AND IRQMASK). It is driven combinationally from registers only.

## Timing
- Reset values:
  - `out_port` = `OUT_RESET`, `oe` = `DIR_RESET`.
  - IRQMASK = 0, EDGECAP = 0, `readdata` = 0, `irq` = 0.
  - Synchroniser and history flops = 0; priming counter = 0.
- Writes take effect at the clock edge that samples them. `out_port`/`oe` change in the following cycle.
- Read latency is 1: `readdata` is valid in the cycle after the read is sampled. It holds its value until the next read.
- A read and a register update in the same cycle return the pre-update value.
- Pin to EDGECAP: an `in_port` change is captured 3 edges after it is first sampled. `irq` rises in the same cycle as the EDGECAP bit when the mask bit is set.
- Reset asserted mid-operation clears all state immediately, including the priming counter, so priming restarts.

## Structure
- Package `myniosiicpu_gpio_pkg` holds:
  - address constants `GPIO_ADDR_DATA`…`GPIO_ADDR_OUTCLR`;
  - edge-mode constants `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- Sub-module `myniosiicpu_gpio_sync`: `WIDTH`-bit two-flop synchroniser, history flop and edge detector with a priming enable input. Top level holds the registers, read mux and irq.

## Test plan
- Reset with `OUT_RESET`=8'hA5, `DIR_RESET`=8'hFF → `out_port`=A5, `oe`=FF, `irq`=0. Read DATA → `readdata`=32'h000000A5 one cycle later.
- Write DATA=0x0F, then OUTSET=0xF0, then OUTCLR=0x81 → `out_port` becomes 0F, then FF, then 7E. Reads of addresses 4, 5, 6 and 7 return 0.
- DIR=0x0F, `in_port`=0xA0, out register 0x05 → DATA read returns 0xA5 once 3 cycles have elapsed after the `in_port` change.
- `EDGE_MODE`=0, IRQMASK=0x01, `in_port[0]` 0→1 → EDGECAP=0x01 and `irq`=1 exactly 3 edges later. A 1→0 transition captures nothing. Write 0x01 to EDGECAP → `irq`=0 next cycle.
- Edge on bit 2 in the same cycle as a write-1 clear of bit 2 → EDGECAP bit 2 stays 1.
- `in_port`=0xFF held through reset, `EDGE_MODE`=0 → EDGECAP stays 0 after release. Reset asserted mid-write → all registers at reset values, and the write is lost.
